// File: rtl/odo_round_key_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | odo_round_key_sched: walks rounds 0..NUM_ROUNDS-1, drives the round-key    |
// | ROM period, and streams keys in order through a 4-entry credit FIFO.       |
// | Optional feature macro: ODO_SCHED_ABORT_EN (adds the abort input).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module odo_round_key_sched #(
  parameter int NUM_ROUNDS = 84,
  parameter int PERIODS    = 9,
  parameter int KEY_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       rom_period,
  input  logic [KEY_W-1:0] rom_key,
  output logic             key_valid,
  input  logic             key_ready,
`ifdef ODO_SCHED_ABORT_EN
  input  logic             abort,
`endif
  output logic [KEY_W-1:0] key,
  output logic [6:0]       key_round,
  output logic             key_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] c_period_max = 4'(PERIODS - 1);
  localparam logic [6:0] c_round_max  = 7'(NUM_ROUNDS - 1);
  localparam int         c_ent_w      = KEY_W + 8;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [3:0]         r_rom_period;
  logic [3:0]         r_pcnt;
  logic [6:0]         r_rcnt;
  logic               r_s1_v;
  logic [6:0]         r_s1_round;
  logic               r_s1_last;
  logic               r_s2_v;
  logic [6:0]         r_s2_round;
  logic               r_s2_last;
  logic [c_ent_w-1:0] r_mem [4];
  logic [1:0]         r_wp;
  logic [1:0]         r_rp;
  logic [2:0]         r_cnt;

  logic               w_abort_req;
  logic               w_abort;
  logic               w_start;
  logic [2:0]         w_occ;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [c_ent_w-1:0] w_head;

`ifdef ODO_SCHED_ABORT_EN
  assign w_abort_req = abort;
`else
  assign w_abort_req = 1'b0;
`endif

  // Abort only acts while busy, but in IDLE it still masks a coincident start.
  assign w_abort = w_abort_req && (r_state != S_IDLE);
  assign w_start = start && !w_abort_req && (r_state == S_IDLE);
  assign w_occ   = r_cnt + {2'b00, r_s1_v} + {2'b00, r_s2_v};
  assign w_issue = w_start || ((r_state == S_ISSUE) && (w_occ < 3'd4));
  assign w_push  = r_s2_v;
  assign w_pop   = key_valid && key_ready;
  assign w_head  = r_mem[r_rp];

  assign busy       = r_busy;
  assign done       = r_done;
  assign rom_period = r_rom_period;
  assign key_valid  = (r_cnt != 3'd0);
  assign key        = key_valid ? w_head[c_ent_w-1:8] : '0;
  assign key_round  = key_valid ? w_head[7:1] : 7'd0;
  assign key_last   = key_valid && w_head[0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= {rom_key, r_s2_round, r_s2_last};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rom_period <= 4'd0;
      r_pcnt       <= 4'd0;
      r_rcnt       <= 7'd0;
      r_s1_v       <= 1'b0;
      r_s1_round   <= 7'd0;
      r_s1_last    <= 1'b0;
      r_s2_v       <= 1'b0;
      r_s2_round   <= 7'd0;
      r_s2_last    <= 1'b0;
      r_wp         <= 2'd0;
      r_rp         <= 2'd0;
      r_cnt        <= 3'd0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pcnt  <= 4'd0;
      r_rcnt  <= 7'd0;
      r_s1_v  <= 1'b0;
      r_s2_v  <= 1'b0;
      r_wp    <= 2'd0;
      r_rp    <= 2'd0;
      r_cnt   <= 3'd0;
    end else begin
      // Tag follows the key through the period register and the ROM register.
      r_s2_v     <= r_s1_v;
      r_s2_round <= r_s1_round;
      r_s2_last  <= r_s1_last;
      r_s1_v     <= w_issue;
      if (w_issue) begin
        r_rom_period <= r_pcnt;
        r_s1_round   <= r_rcnt;
        r_s1_last    <= (r_rcnt == c_round_max);
        r_pcnt       <= (r_pcnt == c_period_max) ? 4'd0 : r_pcnt + 4'd1;
        r_rcnt       <= r_rcnt + 7'd1;
      end
      if (w_push) begin
        r_wp <= r_wp + 2'd1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 2'd1;
      end
      r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};

      case (r_state)
        S_IDLE, S_ISSUE: begin
          if (w_issue) begin
            r_busy  <= 1'b1;
            r_state <= (r_rcnt == c_round_max) ? S_DRAIN : S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_head[0]) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_pcnt  <= 4'd0;
          r_rcnt  <= 7'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_odo_round_key_sched.sv
`default_nettype none
// Bench for odo_round_key_sched: random ROM contents and key_ready patterns,
// scoreboard of expected keys drained by a negedge monitor.
module tb_odo_round_key_sched;
  localparam int N  = 84;
  localparam int P  = 9;
  localparam int KW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, start = 1'b0, key_ready = 1'b0, abort_tb = 1'b0;
  logic          busy, done, key_valid, key_last;
  logic [3:0]    rom_period;
  logic [KW-1:0] rom_key, key;
  logic [6:0]    key_round;
  logic [KW-1:0] tbl [16];

  logic          start1 = 1'b0;
  logic          busy1, done1, key_valid1, key_last1;
  logic [3:0]    rom_period1;
  logic [KW-1:0] rom_key1, key1;
  logic [6:0]    key_round1;
  logic [KW-1:0] tbl1 [16];

  always @(posedge clk) rom_key  <= tbl[rom_period];
  always @(posedge clk) rom_key1 <= tbl1[rom_period1];

  odo_round_key_sched #(.NUM_ROUNDS(N), .PERIODS(P), .KEY_W(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rom_period(rom_period), .rom_key(rom_key), .key_valid(key_valid),
    .key_ready(key_ready),
`ifdef ODO_SCHED_ABORT_EN
    .abort(abort_tb),
`endif
    .key(key), .key_round(key_round), .key_last(key_last));

  odo_round_key_sched #(.NUM_ROUNDS(1), .PERIODS(1), .KEY_W(KW)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .rom_period(rom_period1), .rom_key(rom_key1), .key_valid(key_valid1),
    .key_ready(1'b1),
`ifdef ODO_SCHED_ABORT_EN
    .abort(1'b0),
`endif
    .key(key1), .key_round(key_round1), .key_last(key_last1));

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [KW-1:0] k;
    int            r;
    bit            l;
    int            c;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  bit             mon_en = 1'b0;
  bit             prev_stall = 1'b0;
  logic [KW+7:0]  prev_out;
  int             hs_cnt = 0;
  int             exp_done_cyc = -1;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rom_period_range", rom_period < P, 1);
      if (prev_stall) begin
        chk("stall_valid_held", key_valid, 1);
        chk("stall_key_held", {key, key_round, key_last}, prev_out);
      end
      if (key_valid && key_ready) begin
        chk("key_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          chk("key_value", key, mon_e.k);
          chk("key_round", key_round, mon_e.r);
          chk("key_last", key_last, mon_e.l);
          if (mon_e.c >= 0) chk("key_cycle", cyc, mon_e.c);
          hs_cnt++;
          if (mon_e.l) exp_done_cyc = cyc + 1;
        end
      end
      if (done) begin
        chk("done_cycle", cyc, exp_done_cyc);
        chk("done_handshakes", hs_cnt, N);
        hs_cnt = 0;
        exp_done_cyc = -1;
      end else if (cyc == exp_done_cyc) begin
        chk("done_missing", done, 1);
        exp_done_cyc = -1;
      end
      prev_stall = key_valid && !key_ready && !reset && !abort_tb;
      prev_out   = {key, key_round, key_last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_table();
    for (int i = 0; i < 16; i++) tbl[i] = KW'($urandom);
  endtask

  task automatic issue_start(input bit timed);
    exp_t e;
    for (int r = 0; r < N; r++) begin
      e.k = tbl[r % P];
      e.r = r;
      e.l = (r == N - 1);
      e.c = timed ? cyc + 3 + r : -1;
      q.push_back(e);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic flush_model();
    q.delete();
    exp_done_cyc = -1;
    hs_cnt = 0;
  endtask

  task automatic wait_round(input int r);
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (key_valid && key_round == 7'(r)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_round_seen", found, 1);
  endtask

  // mode 0: ready unchanged, 2: toggle each cycle, 3: random
  task automatic run_until_done(input int mode);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (mode == 2) key_ready = ~key_ready;
      else if (mode == 3) key_ready = 1'($urandom_range(0, 1));
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    chk("busy_in_done", busy, 1);
    tick();
    chk("busy_after_done", busy, 0);
    key_ready = 1'b1;
  endtask

  initial begin
    logic [3:0] p5;
    new_table();
    for (int i = 0; i < 16; i++) tbl1[i] = KW'($urandom);
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_key", key, 0);
    chk("rst_round", key_round, 0);
    chk("rst_last", key_last, 0);
    chk("rst_rom_period", rom_period, 0);
    mon_en = 1'b1;

    // Back-to-back streaming with exact cycle expectations.
    key_ready = 1'b1;
    tick();
    issue_start(1'b1);
    run_until_done(0);

    // Consumer stall for 10 cycles starting when round 5 is presented.
    new_table();
    tick();
    issue_start(1'b0);
    wait_round(5);
    key_ready = 1'b0;
    p5 = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) p5 = rom_period;
      tick();
    end
    chk("stall_period_frozen", rom_period, p5);
    chk("stall_credit_limit", rom_period, (4 + 4) % P);
    key_ready = 1'b1;
    run_until_done(0);

    // key_ready toggling every cycle.
    new_table();
    tick();
    issue_start(1'b0);
    run_until_done(2);

    // Random key_ready.
    for (int s = 0; s < 2; s++) begin
      new_table();
      tick();
      issue_start(1'b0);
      run_until_done(3);
    end

    // Reset in the middle of a sequence, then a clean restart.
    new_table();
    tick();
    issue_start(1'b0);
    wait_round(40);
    reset = 1'b1;
    key_ready = 1'b0;
    flush_model();
    tick();
    reset = 1'b0;
    key_ready = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_valid", key_valid, 0);
    chk("midrst_key", key, 0);
    chk("midrst_round", key_round, 0);
    chk("midrst_last", key_last, 0);
    chk("midrst_rom_period", rom_period, 0);
    repeat (5) tick();
    chk("midrst_quiet", key_valid, 0);
    issue_start(1'b1);
    run_until_done(0);

`ifdef ODO_SCHED_ABORT_EN
    new_table();
    tick();
    issue_start(1'b0);
    wait_round(20);
    abort_tb = 1'b1;
    key_ready = 1'b0;
    flush_model();
    tick();
    abort_tb = 1'b0;
    key_ready = 1'b1;
    chk("abort_valid", key_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (3) tick();
    abort_tb = 1'b1;
    start = 1'b1;
    tick();
    abort_tb = 1'b0;
    start = 1'b0;
    chk("abort_start_idle", busy, 0);
    repeat (5) tick();
    chk("abort_start_quiet", key_valid, 0);
    new_table();
    issue_start(1'b1);
    run_until_done(0);
`endif

    // Single-round, single-period instance; extra starts while busy are ignored.
    mon_en = 1'b0;
    start1 = 1'b1;
    tick();
    for (int c = 1; c <= 7; c++) begin
      chk("n1_valid", key_valid1, c == 3);
      chk("n1_last", key_last1, c == 3);
      chk("n1_done", done1, c == 4);
      chk("n1_busy", busy1, c <= 4);
      chk("n1_rom_period", rom_period1, 0);
      if (c == 3) begin
        chk("n1_key", key1, tbl1[0]);
        chk("n1_round", key_round1, 0);
      end
      start1 = (c <= 2);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
